// File: rtl/nes_mem_arbiter.sv
// CPU/PPU/refresh arbiter in front of the NES SDRAM bridge: one-deep request slots,
// single-issue strobes to the bridge, registered read data with per-client ack pulses.
module nes_mem_arbiter #(
  parameter int unsigned DATA_LATENCY     = 4,
  parameter int unsigned REFRESH_INTERVAL = 1024,
  parameter int unsigned ADDR_WIDTH       = 22
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [7:0]            cpu_din,
  output logic [7:0]            cpu_dout,
  output logic                  cpu_ack,
  input  logic                  ppu_rd,
  input  logic [ADDR_WIDTH-1:0] ppu_addr,
  output logic [7:0]            ppu_dout,
  output logic                  ppu_ack,
  output logic                  mc_read_a,
  output logic                  mc_read_b,
  output logic                  mc_write,
  output logic                  mc_refresh,
  output logic [ADDR_WIDTH-1:0] mc_addr,
  output logic [7:0]            mc_din,
  input  logic                  mc_busy,
  input  logic [7:0]            mc_dout_a,
  input  logic [7:0]            mc_dout_b,
  output logic [2:0]            overrun
);

  localparam int unsigned CntW = $clog2(DATA_LATENCY + 2) + 1;
  // Count is 1 in the strobe cycle, so read data is valid when it reaches DATA_LATENCY+1.
  localparam logic [CntW-1:0] SampleCnt = CntW'(DATA_LATENCY + 1);
  localparam logic [15:0]     RefLast   = 16'(REFRESH_INTERVAL - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWait  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  localparam logic [1:0] KindRef   = 2'd0;
  localparam logic [1:0] KindCpuRd = 2'd1;
  localparam logic [1:0] KindCpuWr = 2'd2;
  localparam logic [1:0] KindPpuRd = 2'd3;

  logic [1:0]            state_q;
  logic [CntW-1:0]       wait_cnt_q;
  logic [1:0]            kind_q;
  logic                  last_ppu_q;

  logic                  cpu_pend_q;
  logic                  cpu_is_wr_q;
  logic [ADDR_WIDTH-1:0] cpu_addr_q;
  logic [7:0]            cpu_din_q;
  logic                  ppu_pend_q;
  logic [ADDR_WIDTH-1:0] ppu_addr_q;
  logic                  ref_pend_q;
  logic [15:0]           ref_cnt_q;

  logic                  read_a_q;
  logic                  read_b_q;
  logic                  write_q;
  logic                  refresh_q;
  logic [ADDR_WIDTH-1:0] mc_addr_q;
  logic [7:0]            mc_din_q;
  logic [7:0]            cpu_dout_q;
  logic [7:0]            ppu_dout_q;
  logic                  cpu_ack_q;
  logic                  ppu_ack_q;
  logic [2:0]            overrun_q;

  logic any_pend;
  logic grant_any;
  logic grant_ref;
  logic grant_cpu;
  logic grant_ppu;
  logic ref_wrap;
  logic cpu_req;
  logic sample;

  always_comb begin
    any_pend  = ref_pend_q | cpu_pend_q | ppu_pend_q;
    grant_any = (state_q == StIdle) && !mc_busy && any_pend;
    grant_ref = grant_any && ref_pend_q;
    // Round-robin: with both clients pending, the one not granted last wins.
    grant_cpu = grant_any && !ref_pend_q && cpu_pend_q && (!ppu_pend_q || last_ppu_q);
    grant_ppu = grant_any && !ref_pend_q && !grant_cpu && ppu_pend_q;
    ref_wrap  = (ref_cnt_q == RefLast);
    cpu_req   = cpu_rd | cpu_wr;
    sample    = (state_q == StWait) && (wait_cnt_q == SampleCnt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
    end else begin
      ref_cnt_q  <= ref_wrap ? '0 : ref_cnt_q + 16'd1;
      ref_pend_q <= ref_wrap | (ref_pend_q & ~grant_ref);
    end
  end

  // A grant reads the old slot contents; a same-cycle request refills the slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_pend_q  <= 1'b0;
      cpu_is_wr_q <= 1'b0;
      cpu_addr_q  <= '0;
      cpu_din_q   <= '0;
      ppu_pend_q  <= 1'b0;
      ppu_addr_q  <= '0;
    end else begin
      if (cpu_req) begin
        cpu_pend_q  <= 1'b1;
        cpu_is_wr_q <= cpu_wr;
        cpu_addr_q  <= cpu_addr;
        cpu_din_q   <= cpu_din;
      end else if (grant_cpu) begin
        cpu_pend_q <= 1'b0;
      end
      if (ppu_rd) begin
        ppu_pend_q <= 1'b1;
        ppu_addr_q <= ppu_addr;
      end else if (grant_ppu) begin
        ppu_pend_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q <= '0;
    end else begin
      overrun_q <= overrun_q | {ref_wrap & ref_pend_q & ~grant_ref,
                                ppu_rd & ppu_pend_q & ~grant_ppu,
                                cpu_req & cpu_pend_q & ~grant_cpu};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      read_a_q   <= 1'b0;
      read_b_q   <= 1'b0;
      write_q    <= 1'b0;
      refresh_q  <= 1'b0;
      mc_addr_q  <= '0;
      mc_din_q   <= '0;
      kind_q     <= KindRef;
      last_ppu_q <= 1'b1;
    end else begin
      read_a_q  <= grant_cpu & ~cpu_is_wr_q;
      read_b_q  <= grant_ppu;
      write_q   <= grant_cpu & cpu_is_wr_q;
      refresh_q <= grant_ref;
      if (grant_ref) begin
        mc_addr_q <= '0;
        kind_q    <= KindRef;
      end else if (grant_cpu) begin
        mc_addr_q  <= cpu_addr_q;
        mc_din_q   <= cpu_din_q;
        kind_q     <= cpu_is_wr_q ? KindCpuWr : KindCpuRd;
        last_ppu_q <= 1'b0;
      end else if (grant_ppu) begin
        mc_addr_q  <= ppu_addr_q;
        kind_q     <= KindPpuRd;
        last_ppu_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant_any) begin
            state_q    <= StWait;
            wait_cnt_q <= CntW'(1);
          end
        end
        StWait: begin
          wait_cnt_q <= wait_cnt_q + CntW'(1);
          if (sample) state_q <= StDrain;
        end
        StDrain: begin
          if (!mc_busy) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_dout_q <= '0;
      ppu_dout_q <= '0;
      cpu_ack_q  <= 1'b0;
      ppu_ack_q  <= 1'b0;
    end else begin
      cpu_ack_q <= 1'b0;
      ppu_ack_q <= 1'b0;
      if (sample) begin
        case (kind_q)
          KindCpuRd: begin
            cpu_dout_q <= mc_dout_a;
            cpu_ack_q  <= 1'b1;
          end
          KindCpuWr: cpu_ack_q <= 1'b1;
          KindPpuRd: begin
            ppu_dout_q <= mc_dout_b;
            ppu_ack_q  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign mc_read_a  = read_a_q;
  assign mc_read_b  = read_b_q;
  assign mc_write   = write_q;
  assign mc_refresh = refresh_q;
  assign mc_addr    = mc_addr_q;
  assign mc_din     = mc_din_q;
  assign cpu_dout   = cpu_dout_q;
  assign ppu_dout   = ppu_dout_q;
  assign cpu_ack    = cpu_ack_q;
  assign ppu_ack    = ppu_ack_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_nes_mem_arbiter.sv
// Bench for nes_mem_arbiter: table-driven single transactions, directed corner sequences and
// random traffic, all checked cycle by cycle against a timestamp-based reference model.
module tb_nes_mem_arbiter;

  localparam int unsigned L  = 4;
  localparam int unsigned RI = 16;
  localparam int KRef = 0, KCpuRd = 1, KCpuWr = 2, KPpuRd = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0, ppu_rd = 1'b0, mc_busy = 1'b0;
  logic [21:0] cpu_addr = '0, ppu_addr = '0;
  logic [7:0]  cpu_din = '0, mc_dout_a = '0, mc_dout_b = '0;
  logic [7:0]  cpu_dout, ppu_dout, mc_din;
  logic        cpu_ack, ppu_ack, mc_read_a, mc_read_b, mc_write, mc_refresh;
  logic [21:0] mc_addr;
  logic [2:0]  overrun;
  logic [3:0]  dut_strobe;
  logic [1:0]  acks;

  assign dut_strobe = {mc_read_a, mc_read_b, mc_write, mc_refresh};
  assign acks       = {cpu_ack, ppu_ack};

  nes_mem_arbiter #(
    .DATA_LATENCY(L),
    .REFRESH_INTERVAL(RI),
    .ADDR_WIDTH(22)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .ppu_rd(ppu_rd), .ppu_addr(ppu_addr), .ppu_dout(ppu_dout), .ppu_ack(ppu_ack),
    .mc_read_a(mc_read_a), .mc_read_b(mc_read_b), .mc_write(mc_write),
    .mc_refresh(mc_refresh), .mc_addr(mc_addr), .mc_din(mc_din), .mc_busy(mc_busy),
    .mc_dout_a(mc_dout_a), .mc_dout_b(mc_dout_b), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  // Reference model: m_t is the cycle whose inputs are being driven; m_g is the grant cycle.
  int unsigned m_t, m_g;
  int          m_kind;
  bit          m_idle, m_cpu_pend, m_cpu_wr, m_ppu_pend, m_ref_pend, m_last_ppu;
  logic [21:0] m_cpu_addr, m_ppu_addr, m_addr;
  logic [7:0]  m_cpu_din, m_din, m_cpu_dout, m_ppu_dout;
  logic [3:0]  m_strobe;
  logic [1:0]  m_ack;
  logic [2:0]  m_overrun;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got 0x%0h, required 0x%0h", name, m_t, act, exp);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_g = 0; m_kind = KRef; m_idle = 1'b1;
    m_cpu_pend = 0; m_cpu_wr = 0; m_ppu_pend = 0; m_ref_pend = 0; m_last_ppu = 1'b1;
    m_cpu_addr = '0; m_ppu_addr = '0; m_addr = '0; m_cpu_din = '0; m_din = '0;
    m_cpu_dout = '0; m_ppu_dout = '0; m_strobe = '0; m_ack = '0; m_overrun = '0;
  endtask

  task automatic model_step();
    logic [3:0] s;
    logic [1:0] a;
    bit gr_ref, gr_cpu, gr_ppu;
    s = '0; a = '0; gr_ref = 0; gr_cpu = 0; gr_ppu = 0;
    if (!m_idle && m_t == m_g + 1 + L) begin
      case (m_kind)
        KCpuRd: begin m_cpu_dout = mc_dout_a; a = 2'b10; end
        KCpuWr: a = 2'b10;
        KPpuRd: begin m_ppu_dout = mc_dout_b; a = 2'b01; end
        default: ;
      endcase
    end
    if (m_idle && !mc_busy) begin
      if (m_ref_pend) gr_ref = 1;
      else if (m_cpu_pend && (!m_ppu_pend || m_last_ppu)) gr_cpu = 1;
      else if (m_ppu_pend) gr_ppu = 1;
    end
    if (!m_idle && m_t >= m_g + L + 2 && !mc_busy) m_idle = 1'b1;
    if (gr_ref) begin
      s = 4'b0001; m_addr = '0; m_kind = KRef; m_ref_pend = 0;
    end else if (gr_cpu) begin
      s = m_cpu_wr ? 4'b0010 : 4'b1000; m_addr = m_cpu_addr; m_din = m_cpu_din;
      m_kind = m_cpu_wr ? KCpuWr : KCpuRd; m_cpu_pend = 0; m_last_ppu = 0;
    end else if (gr_ppu) begin
      s = 4'b0100; m_addr = m_ppu_addr; m_kind = KPpuRd; m_ppu_pend = 0; m_last_ppu = 1;
    end
    if (gr_ref || gr_cpu || gr_ppu) begin
      m_idle = 1'b0; m_g = m_t;
    end
    if (cpu_rd || cpu_wr) begin
      if (m_cpu_pend) m_overrun[0] = 1'b1;
      m_cpu_pend = 1; m_cpu_wr = cpu_wr; m_cpu_addr = cpu_addr; m_cpu_din = cpu_din;
    end
    if (ppu_rd) begin
      if (m_ppu_pend) m_overrun[1] = 1'b1;
      m_ppu_pend = 1; m_ppu_addr = ppu_addr;
    end
    if (m_t % RI == RI - 1) begin
      if (m_ref_pend) m_overrun[2] = 1'b1;
      m_ref_pend = 1;
    end
    m_strobe = s; m_ack = a; m_t++;
  endtask

  task automatic compare_all();
    check("strobe", 32'(dut_strobe), 32'(m_strobe));
    if (m_strobe != 4'b0) check("mc_addr", 32'(mc_addr), 32'(m_addr));
    if (m_strobe == 4'b0010) check("mc_din", 32'(mc_din), 32'(m_din));
    check("acks", 32'(acks), 32'(m_ack));
    check("cpu_dout", 32'(cpu_dout), 32'(m_cpu_dout));
    check("ppu_dout", 32'(ppu_dout), 32'(m_ppu_dout));
    check("overrun", 32'(overrun), 32'(m_overrun));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    cpu_rd = 0; cpu_wr = 0; ppu_rd = 0;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1; cpu_rd = 0; cpu_wr = 0; ppu_rd = 0; mc_busy = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_strobe", 32'(dut_strobe), 32'h0);
    check("rst_addr", 32'(mc_addr), 32'h0);
    check("rst_din", 32'(mc_din), 32'h0);
    check("rst_acks", 32'(acks), 32'h0);
    check("rst_cpu_dout", 32'(cpu_dout), 32'h0);
    check("rst_ppu_dout", 32'(ppu_dout), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    reset = 0;
    model_reset();
  endtask

  task automatic wait_strobe(input logic [3:0] want, input string name,
                             output int unsigned at, output bit ok);
    ok = 0; at = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if ((dut_strobe & want) != 4'b0) begin
        ok = 1; at = m_t;
        break;
      end
    end
    if (!ok) begin
      n_checks++; n_err++;
      $display("FAIL %s: got no strobe in 200 cycles, required one", name);
    end
  endtask

  typedef struct {
    bit          is_ppu;
    bit          is_wr;
    logic [21:0] addr;
    logic [7:0]  din;
    logic [7:0]  rdata;
    logic [3:0]  exp_strobe;
    logic [1:0]  exp_ack;
    logic [7:0]  exp_cpu_dout;
    logic [7:0]  exp_ppu_dout;
  } vec_t;

  vec_t        vecs[8];
  vec_t        v;
  int unsigned t_s, ta, tb, rf[3];
  int          na, nb, nrf;
  bit          ok;
  logic [21:0] addr_a, addr_b;

  initial begin
    vecs[0] = '{0, 0, 22'h000123, 8'h00, 8'h5A, 4'b1000, 2'b10, 8'h5A, 8'h00};
    vecs[1] = '{0, 1, 22'h3C0010, 8'hA5, 8'h33, 4'b0010, 2'b10, 8'h5A, 8'h00};
    vecs[2] = '{1, 0, 22'h200020, 8'h00, 8'hC3, 4'b0100, 2'b01, 8'h5A, 8'hC3};
    vecs[3] = '{0, 0, 22'h3FFFFF, 8'h00, 8'hFF, 4'b1000, 2'b10, 8'hFF, 8'hC3};
    vecs[4] = '{1, 0, 22'h000000, 8'h00, 8'h00, 4'b0100, 2'b01, 8'hFF, 8'h00};
    vecs[5] = '{0, 1, 22'h000000, 8'h00, 8'h77, 4'b0010, 2'b10, 8'hFF, 8'h00};
    vecs[6] = '{0, 1, 22'h155555, 8'h3C, 8'h99, 4'b0010, 2'b10, 8'hFF, 8'h00};
    vecs[7] = '{0, 0, 22'h2AAAAA, 8'h00, 8'h81, 4'b1000, 2'b10, 8'h81, 8'h00};

    model_reset();
    do_reset();

    // Table: one transaction at a time; the idle port carries inverted data.
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      if (v.is_ppu) begin
        mc_dout_b = v.rdata; mc_dout_a = ~v.rdata; ppu_rd = 1; ppu_addr = v.addr;
      end else begin
        mc_dout_a = v.rdata; mc_dout_b = ~v.rdata;
        cpu_rd = !v.is_wr; cpu_wr = v.is_wr; cpu_addr = v.addr; cpu_din = v.din;
      end
      tick();
      wait_strobe(4'b1110, "vec_strobe", t_s, ok);
      if (ok) begin
        check("vec_kind", 32'(dut_strobe), 32'(v.exp_strobe));
        check("vec_addr", 32'(mc_addr), 32'(v.addr));
        if (v.is_wr) check("vec_din", 32'(mc_din), 32'(v.din));
        for (int k = 1; k <= 5; k++) begin
          tick();
          if (k == 4) check("vec_ack_early", 32'(acks), 32'h0);
        end
        check("vec_ack", 32'(acks), 32'(v.exp_ack));
        check("vec_cpu_dout", 32'(cpu_dout), 32'(v.exp_cpu_dout));
        check("vec_ppu_dout", 32'(ppu_dout), 32'(v.exp_ppu_dout));
      end
      repeat (3) tick();
    end

    // Simultaneous CPU and PPU reads right after reset: CPU goes first.
    do_reset();
    cpu_rd = 1; cpu_addr = 22'h000010; ppu_rd = 1; ppu_addr = 22'h200020;
    tick();
    ta = 0; tb = 0; na = 0; nb = 0; addr_a = '0; addr_b = '0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (mc_read_a && ta == 0) begin ta = m_t; addr_a = mc_addr; end
      if (mc_read_b && tb == 0) begin tb = m_t; addr_b = mc_addr; end
      if (cpu_ack) na++;
      if (ppu_ack) nb++;
    end
    check("rr_cpu_first", 32'(ta != 0 && tb > ta), 32'h1);
    check("rr_gap_ge6", 32'(tb >= ta + 6), 32'h1);
    check("rr_addr_a", 32'(addr_a), 32'h000010);
    check("rr_addr_b", 32'(addr_b), 32'h200020);
    check("rr_cpu_acks", 32'(na), 32'h1);
    check("rr_ppu_acks", 32'(nb), 32'h1);

    // Refresh cadence with no traffic.
    do_reset();
    nrf = 0; rf[0] = 0; rf[1] = 0; rf[2] = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (mc_refresh && nrf < 3) begin rf[nrf] = m_t; nrf++; end
    end
    check("ref_first", rf[0], 32'd17);
    check("ref_period1", rf[1] - rf[0], 32'd16);
    check("ref_period2", rf[2] - rf[1], 32'd16);

    // CPU request pending at a wrap is issued after the refresh.
    do_reset();
    while (m_t < 15) tick();
    cpu_rd = 1; cpu_addr = 22'h00AAAA;
    tick();
    ta = 0; tb = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (mc_refresh && tb == 0) tb = m_t;
      if (mc_read_a && ta == 0) ta = m_t;
    end
    check("wrap_ref_at", tb, 32'd17);
    check("wrap_cpu_after", 32'(ta > tb), 32'h1);

    // Bridge busy for 40 cycles with a PPU read pending, then an overwriting request.
    do_reset();
    mc_busy = 1; ppu_rd = 1; ppu_addr = 22'h0ABCDE;
    tick();
    for (int i = 0; i < 40; i++) begin
      if (i == 20) begin ppu_rd = 1; ppu_addr = 22'h1F0F0F; end
      tick();
      check("busy_no_strobe", 32'(dut_strobe), 32'h0);
    end
    check("busy_overrun_ppu", 32'(overrun[1]), 32'h1);
    mc_busy = 0;
    wait_strobe(4'b0100, "busy_ppu_strobe", t_s, ok);
    if (ok) check("busy_ppu_addr", 32'(mc_addr), 32'h1F0F0F);
    repeat (8) tick();

    // Reset in the middle of a CPU read.
    do_reset();
    cpu_rd = 1; cpu_addr = 22'h012345; mc_dout_a = 8'h6B;
    tick();
    wait_strobe(4'b1000, "rst_mid_strobe", t_s, ok);
    repeat (2) tick();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_mid_no_ack", 32'(cpu_ack), 32'h0);
    end

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      mc_busy   = ($urandom_range(0, 99) < 25);
      cpu_rd    = (r < 8);
      cpu_wr    = (r >= 8 && r < 14);
      cpu_addr  = 22'($urandom);
      cpu_din   = 8'($urandom);
      ppu_rd    = ($urandom_range(0, 99) < 10);
      ppu_addr  = 22'($urandom);
      mc_dout_a = 8'($urandom);
      mc_dout_b = 8'($urandom);
      tick();
    end
    mc_busy = 0;
    repeat (20) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
